execute_stage: RTL and testbench

- Second CPU pipeline stage. Sits directly downstream of the fetch/decode stage and upstream of the memory/writeback stage.
- Consumes the registered decode outputs: opcode, operands, immediate, source register numbers and control bits.
- Performs ALU operations, byte-immediate merges, load/store address generation and an iterative 16-cycle multiply, with operand forwarding.
- Registers results and control into the EX/MEM boundary, holds the NVZ flag register that drives branch evaluation in fetch/decode, and drives the pipeline stall.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/execute_stage_if.sv | 49 ++++
 rtl/seq_multiplier.sv | 47 ++++
 rtl/execute_stage.sv | 164 ++++++++++++++++
 tb/tb_execute_stage.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, execute-stage FSM states, flag bit positions.
// No logic; pure declarations used by decode and execute.
// Backpressure: not applicable.
package cpu_pkg;

  localparam int DW         = 16;
  localparam int MUL_CYCLES = 16;

  // 5-bit opcodes, shared with fetch/decode
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_NOP  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_IMML = 5'b01000;
  localparam logic [4:0] OP_IMMH = 5'b01001;
  localparam logic [4:0] OP_LD   = 5'b01010;
  localparam logic [4:0] OP_ST   = 5'b01011;
  localparam logic [4:0] OP_DBLD = 5'b01100;
  localparam logic [4:0] OP_DBST = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;

  // Bit positions inside the {N,V,Z} flag register
  localparam int NVZ_N = 2;
  localparam int NVZ_V = 1;
  localparam int NVZ_Z = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ex_state_e;

  // Writeback / memory control carried across the EX/MEM boundary
  typedef struct packed {
    logic       wr;
    logic [3:0] addr;
    logic       memtoreg;
    logic       bustoreg;
    logic       memread;
    logic       memwrite;
    logic       buswrite;
  } ex_ctrl_t;

endpackage

// File: rtl/execute_stage_if.sv
// Decode-to-execute inputs, MEM/WB forwarding inputs and EX/MEM outputs.
// Latency: none (wires only).
// Backpressure: oStall travels back towards decode on this bundle.
interface execute_stage_if #(parameter int DW = 16);
  logic [4:0]    iOpcode;
  logic [DW-1:0] iData1;
  logic [DW-1:0] iData2;
  logic [DW-1:0] iImm;
  logic [3:0]    iSr1;
  logic [3:0]    iSr2;
  logic          iALUSrc;
  logic          iWriteReg;
  logic [3:0]    iWriteRegAddr;
  logic          iMemtoReg;
  logic          iBustoReg;
  logic          iMemRead;
  logic          iMemWrite;
  logic          iBusWrite;
  logic          iWBWriteReg;
  logic [3:0]    iWBAddr;
  logic [DW-1:0] iWBData;
  logic [DW-1:0] oResult;
  logic [DW-1:0] oStoreData;
  logic          oWriteReg;
  logic [3:0]    oWriteRegAddr;
  logic          oMemtoReg;
  logic          oBustoReg;
  logic          oMemRead;
  logic          oMemWrite;
  logic          oBusWrite;
  logic [2:0]    oNVZ;
  logic          oStall;

  modport master (
    output iOpcode, iData1, iData2, iImm, iSr1, iSr2, iALUSrc, iWriteReg,
           iWriteRegAddr, iMemtoReg, iBustoReg, iMemRead, iMemWrite, iBusWrite,
           iWBWriteReg, iWBAddr, iWBData,
    input  oResult, oStoreData, oWriteReg, oWriteRegAddr, oMemtoReg, oBustoReg,
           oMemRead, oMemWrite, oBusWrite, oNVZ, oStall
  );

  modport slave (
    input  iOpcode, iData1, iData2, iImm, iSr1, iSr2, iALUSrc, iWriteReg,
           iWriteRegAddr, iMemtoReg, iBustoReg, iMemRead, iMemWrite, iBusWrite,
           iWBWriteReg, iWBAddr, iWBData,
    output oResult, oStoreData, oWriteReg, oWriteRegAddr, oMemtoReg, oBustoReg,
           oMemRead, oMemWrite, oBusWrite, oNVZ, oStall
  );
endinterface

// File: rtl/seq_multiplier.sv
// Shift-add multiplier producing the low DW bits of a*b, one partial product per step.
// Latency: MUL_CYCLES steps after start; product is valid combinationally during the last step.
// Backpressure: none; the owner sequences start/step.
module seq_multiplier #(
  parameter int DW         = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic          iclk,
  input  logic          irst_n,
  input  logic          start,
  input  logic          step,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] product,
  output logic          done
);
  localparam int CW = $clog2(MUL_CYCLES);

  logic [DW-1:0] mcand_q;
  logic [DW-1:0] mplier_q;
  logic [DW-1:0] acc_q;
  logic [CW-1:0] cnt_q;

  // Accumulator value after the current step; on the last step this is the full product
  assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = (cnt_q == CW'(MUL_CYCLES - 1));

  // Load operands on start, then shift multiplicand left and multiplier right each step
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/execute_stage.sv
// Execute stage: forwarding, ALU/address generation, iterative multiply, EX/MEM register, NVZ flags.
// Latency: 1 cycle for all ops except MUL, which takes 17 edges.
// Backpressure: oStall holds decode while a multiply is accepted or in progress.
module execute_stage
  import cpu_pkg::*;
#(
  parameter int DW         = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic iclk,
  input  logic irst_n,
  execute_stage_if.slave ex
);
  localparam int SHW = $clog2(DW);

  ex_state_e     state_q, state_d;
  logic          stall, mul_start, mul_step, mul_done, mul_last;
  logic [DW-1:0] mul_prod;
  logic [DW-1:0] fwd_a, fwd_b, op_b, alu_res;
  logic          flag_upd, ovf, exmem_load;
  ex_ctrl_t      dec_ctrl, sav_ctrl_q;

  logic [DW-1:0] res_q, st_q;
  ex_ctrl_t      ctrl_q;
  logic [2:0]    nvz_q;

  assign dec_ctrl   = '{wr: ex.iWriteReg, addr: ex.iWriteRegAddr, memtoreg: ex.iMemtoReg,
                        bustoreg: ex.iBustoReg, memread: ex.iMemRead,
                        memwrite: ex.iMemWrite, buswrite: ex.iBusWrite};
  // A load's EX/MEM value is an address, not the data to be written back
  assign exmem_load = ctrl_q.memtoreg | ctrl_q.bustoreg;

  // Operand forwarding: EX/MEM beats MEM/WB beats the register file; r0 is always zero
  always_comb begin
    fwd_a = ex.iData1;
    fwd_b = ex.iData2;
    if (ex.iSr1 == 4'd0) fwd_a = '0;
    else if (ctrl_q.wr && ctrl_q.addr == ex.iSr1 && !exmem_load) fwd_a = res_q;
    else if (ex.iWBWriteReg && ex.iWBAddr == ex.iSr1) fwd_a = ex.iWBData;
    if (ex.iSr2 == 4'd0) fwd_b = '0;
    else if (ctrl_q.wr && ctrl_q.addr == ex.iSr2 && !exmem_load) fwd_b = res_q;
    else if (ex.iWBWriteReg && ex.iWBAddr == ex.iSr2) fwd_b = ex.iWBData;
  end

  assign op_b = ex.iALUSrc ? ex.iImm : fwd_b;

  // Single-cycle ALU, byte merges and address generation; flags only for arithmetic/logic
  always_comb begin
    alu_res  = '0;
    flag_upd = 1'b0;
    ovf      = 1'b0;
    case (ex.iOpcode)
      OP_ADD: begin
        alu_res  = fwd_a + op_b;
        flag_upd = 1'b1;
        ovf      = (fwd_a[DW-1] == op_b[DW-1]) && (alu_res[DW-1] != fwd_a[DW-1]);
      end
      OP_SUB: begin
        alu_res  = fwd_a - op_b;
        flag_upd = 1'b1;
        ovf      = (fwd_a[DW-1] != op_b[DW-1]) && (alu_res[DW-1] != fwd_a[DW-1]);
      end
      OP_AND:  begin alu_res = fwd_a & op_b;              flag_upd = 1'b1; end
      OP_OR:   begin alu_res = fwd_a | op_b;              flag_upd = 1'b1; end
      OP_XOR:  begin alu_res = fwd_a ^ op_b;              flag_upd = 1'b1; end
      OP_SHL:  begin alu_res = fwd_a << op_b[SHW-1:0];    flag_upd = 1'b1; end
      OP_SHR:  begin alu_res = fwd_a >> op_b[SHW-1:0];    flag_upd = 1'b1; end
      OP_IMML: alu_res = {fwd_a[DW-1:8], ex.iImm[7:0]};
      OP_IMMH: alu_res = {ex.iImm[DW-1:8], fwd_a[7:0]};
      OP_LD, OP_ST, OP_DBLD, OP_DBST: alu_res = fwd_a + ex.iImm;
      default: alu_res = '0;
    endcase
  end

  // Multiply sequencing; stall is masked during reset so decode is released at once
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex.iOpcode == OP_MUL) begin
          stall     = 1'b1;
          mul_start = 1'b1;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall    = 1'b1;
        mul_step = 1'b1;
        if (mul_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mul_done  = (state_q == ST_BUSY) && mul_last;
  assign ex.oStall = stall & irst_n;

  // FSM state register
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Hold the multiply's destination and control until its result is written
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n)        sav_ctrl_q <= '0;
    else if (mul_start) sav_ctrl_q <= dec_ctrl;
  end

  seq_multiplier #(.DW(DW), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .iclk    (iclk),
    .irst_n  (irst_n),
    .start   (mul_start),
    .step    (mul_step),
    .a       (fwd_a),
    .b       (op_b),
    .product (mul_prod),
    .done    (mul_last)
  );

  // EX/MEM register and flags: product on multiply completion, bubble while multiplying
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      res_q  <= '0;
      st_q   <= '0;
      ctrl_q <= '0;
      nvz_q  <= 3'b000;
    end else if (mul_done) begin
      res_q        <= mul_prod;
      st_q         <= '0;
      ctrl_q       <= sav_ctrl_q;
      nvz_q[NVZ_N] <= mul_prod[DW-1];
      nvz_q[NVZ_V] <= 1'b0;
      nvz_q[NVZ_Z] <= (mul_prod == '0);
    end else if (mul_start || state_q == ST_BUSY) begin
      res_q  <= '0;
      st_q   <= '0;
      ctrl_q <= '0;
    end else begin
      res_q  <= alu_res;
      st_q   <= fwd_b;
      ctrl_q <= dec_ctrl;
      if (flag_upd) begin
        nvz_q[NVZ_N] <= alu_res[DW-1];
        nvz_q[NVZ_V] <= ovf;
        nvz_q[NVZ_Z] <= (alu_res == '0);
      end
    end
  end

  assign ex.oResult       = res_q;
  assign ex.oStoreData    = st_q;
  assign ex.oWriteReg     = ctrl_q.wr;
  assign ex.oWriteRegAddr = ctrl_q.addr;
  assign ex.oMemtoReg     = ctrl_q.memtoreg;
  assign ex.oBustoReg     = ctrl_q.bustoreg;
  assign ex.oMemRead      = ctrl_q.memread;
  assign ex.oMemWrite     = ctrl_q.memwrite;
  assign ex.oBusWrite     = ctrl_q.buswrite;
  assign ex.oNVZ          = nvz_q;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU, flags, forwarding, loads/stores, multiply, reset.
module tb_execute_stage;
  logic iclk;
  logic irst_n;
  int   checks;
  int   errors;

  execute_stage_if #(.DW(16)) bus ();

  execute_stage #(.DW(16), .MUL_CYCLES(16)) dut (
    .iclk   (iclk),
    .irst_n (irst_n),
    .ex     (bus)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // ctl = {memtoreg, bustoreg, memread, memwrite, buswrite}
  task automatic drive(input logic [4:0] op, input logic [15:0] d1, input logic [15:0] d2,
                       input logic [15:0] imm, input logic [3:0] sr1, input logic [3:0] sr2,
                       input logic alusrc, input logic wr, input logic [3:0] waddr,
                       input logic [4:0] ctl);
    bus.iOpcode       = op;
    bus.iData1        = d1;
    bus.iData2        = d2;
    bus.iImm          = imm;
    bus.iSr1          = sr1;
    bus.iSr2          = sr2;
    bus.iALUSrc       = alusrc;
    bus.iWriteReg     = wr;
    bus.iWriteRegAddr = waddr;
    {bus.iMemtoReg, bus.iBustoReg, bus.iMemRead, bus.iMemWrite, bus.iBusWrite} = ctl;
  endtask

  task automatic set_wb(input logic wr, input logic [3:0] addr, input logic [15:0] data);
    bus.iWBWriteReg = wr;
    bus.iWBAddr     = addr;
    bus.iWBData     = data;
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic nop();
    drive(5'b00101, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 5'b0);
  endtask

  task automatic test_reset();
    nop();
    set_wb(1'b0, 4'd0, 16'h0);
    irst_n = 1'b0;
    #12;
    checks++; if (bus.oResult !== 16'h0) begin errors++; $display("FAIL reset_result: got %h want 0000", bus.oResult); end
    checks++; if (bus.oWriteReg !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", bus.oWriteReg); end
    checks++; if (bus.oNVZ !== 3'b000) begin errors++; $display("FAIL reset_nvz: got %b want 000", bus.oNVZ); end
    checks++; if (bus.oStall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.oStall); end
    irst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_sub();
    drive(5'b00000, 16'h7FFF, 16'h0001, 16'h0, 4'd1, 4'd2, 1'b0, 1'b1, 4'd5, 5'b0);
    tick();
    checks++; if (bus.oResult !== 16'h8000) begin errors++; $display("FAIL add_result: got %h want 8000", bus.oResult); end
    checks++; if (bus.oNVZ !== 3'b110) begin errors++; $display("FAIL add_nvz: got %b want 110", bus.oNVZ); end
    checks++; if (bus.oWriteReg !== 1'b1 || bus.oWriteRegAddr !== 4'd5) begin errors++; $display("FAIL add_ctrl: got wr=%b addr=%0d want wr=1 addr=5", bus.oWriteReg, bus.oWriteRegAddr); end
    drive(5'b00001, 16'h0005, 16'h0005, 16'h0, 4'd6, 4'd7, 1'b0, 1'b1, 4'd8, 5'b0);
    tick();
    checks++; if (bus.oResult !== 16'h0000) begin errors++; $display("FAIL sub_result: got %h want 0000", bus.oResult); end
    checks++; if (bus.oNVZ !== 3'b001) begin errors++; $display("FAIL sub_nvz: got %b want 001", bus.oNVZ); end
  endtask

  task automatic test_forwarding();
    drive(5'b00000, 16'h0010, 16'h0020, 16'h0, 4'd1, 4'd2, 1'b0, 1'b1, 4'd3, 5'b0);
    tick();
    checks++; if (bus.oResult !== 16'h0030) begin errors++; $display("FAIL fwd_add: got %h want 0030", bus.oResult); end
    drive(5'b00100, 16'h1111, 16'h2222, 16'h0, 4'd3, 4'd3, 1'b0, 1'b1, 4'd4, 5'b0);
    tick();
    checks++; if (bus.oResult !== 16'h0000 || bus.oNVZ !== 3'b001) begin errors++; $display("FAIL fwd_exmem_xor: got %h nvz=%b want 0000 nvz=001", bus.oResult, bus.oNVZ); end
    drive(5'b00000, 16'h0005, 16'h0006, 16'h0, 4'd1, 4'd2, 1'b0, 1'b1, 4'd0, 5'b0);
    tick();
    checks++; if (bus.oResult !== 16'h000B || bus.oWriteRegAddr !== 4'd0 || bus.oWriteReg !== 1'b1) begin errors++; $display("FAIL r0_dest: got %h wr=%b addr=%0d want 000b wr=1 addr=0", bus.oResult, bus.oWriteReg, bus.oWriteRegAddr); end
    set_wb(1'b1, 4'd0, 16'h9999);
    drive(5'b00000, 16'h0022, 16'h0033, 16'h0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd10, 5'b0);
    tick();
    checks++; if (bus.oResult !== 16'h0000) begin errors++; $display("FAIL r0_source: got %h want 0000", bus.oResult); end
    set_wb(1'b1, 4'd9, 16'h0100);
    drive(5'b00000, 16'h5555, 16'h0001, 16'h0, 4'd9, 4'd12, 1'b0, 1'b1, 4'd11, 5'b0);
    tick();
    checks++; if (bus.oResult !== 16'h0101) begin errors++; $display("FAIL fwd_wb: got %h want 0101", bus.oResult); end
    set_wb(1'b1, 4'd11, 16'h7000);
    drive(5'b00000, 16'h0000, 16'h0000, 16'h0, 4'd11, 4'd0, 1'b0, 1'b1, 4'd12, 5'b0);
    tick();
    checks++; if (bus.oResult !== 16'h0101) begin errors++; $display("FAIL fwd_priority: got %h want 0101", bus.oResult); end
    set_wb(1'b0, 4'd0, 16'h0);
  endtask

  task automatic test_load_store();
    drive(5'b00001, 16'h4444, 16'h0001, 16'h0, 4'd0, 4'd2, 1'b0, 1'b1, 4'd13, 5'b0);
    tick();
    checks++; if (bus.oResult !== 16'hFFFF || bus.oNVZ !== 3'b100) begin errors++; $display("FAIL pre_ld_sub: got %h nvz=%b want ffff nvz=100", bus.oResult, bus.oNVZ); end
    drive(5'b01010, 16'h1000, 16'h0000, 16'h0010, 4'd1, 4'd2, 1'b1, 1'b1, 4'd7, 5'b10100);
    tick();
    checks++; if (bus.oResult !== 16'h1010) begin errors++; $display("FAIL ld_addr: got %h want 1010", bus.oResult); end
    checks++; if (bus.oMemRead !== 1'b1 || bus.oMemtoReg !== 1'b1) begin errors++; $display("FAIL ld_ctrl: got rd=%b m2r=%b want 1 1", bus.oMemRead, bus.oMemtoReg); end
    checks++; if (bus.oNVZ !== 3'b100) begin errors++; $display("FAIL ld_flags_held: got %b want 100", bus.oNVZ); end
    drive(5'b00000, 16'h0003, 16'h0000, 16'h0, 4'd7, 4'd0, 1'b0, 1'b1, 4'd14, 5'b0);
    tick();
    checks++; if (bus.oResult !== 16'h0003) begin errors++; $display("FAIL no_fwd_from_load: got %h want 0003", bus.oResult); end
    drive(5'b01011, 16'h2000, 16'hBEEF, 16'h0004, 4'd1, 4'd2, 1'b1, 1'b0, 4'd0, 5'b00010);
    tick();
    checks++; if (bus.oResult !== 16'h2004 || bus.oStoreData !== 16'hBEEF || bus.oMemWrite !== 1'b1) begin errors++; $display("FAIL st: got addr=%h data=%h wr=%b want 2004 beef 1", bus.oResult, bus.oStoreData, bus.oMemWrite); end
  endtask

  task automatic test_mul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    int n;
    drive(5'b01110, a, b, 16'h0, 4'd1, 4'd2, 1'b0, 1'b1, 4'd9, 5'b0);
    #1;
    checks++; if (bus.oStall !== 1'b1) begin errors++; $display("FAIL mul_stall_comb: got %b want 1", bus.oStall); end
    tick();
    nop();
    n = 1;
    while (bus.oStall === 1'b1 && n < 40) begin
      checks++; if (bus.oWriteReg !== 1'b0 || bus.oMemRead !== 1'b0) begin errors++; $display("FAIL mul_bubble: cycle %0d got wr=%b rd=%b want 0 0", n, bus.oWriteReg, bus.oMemRead); end
      n++;
      tick();
    end
    checks++; if (n != 17) begin errors++; $display("FAIL mul_stall_len: got %0d want 17", n); end
    checks++; if (bus.oResult !== exp) begin errors++; $display("FAIL mul_result: got %h want %h", bus.oResult, exp); end
    checks++; if (bus.oWriteReg !== 1'b1 || bus.oWriteRegAddr !== 4'd9) begin errors++; $display("FAIL mul_ctrl: got wr=%b addr=%0d want 1 9", bus.oWriteReg, bus.oWriteRegAddr); end
    checks++; if (bus.oNVZ !== 3'b000) begin errors++; $display("FAIL mul_nvz: got %b want 000", bus.oNVZ); end
  endtask

  task automatic test_reset_mid_mul();
    drive(5'b00001, 16'h0000, 16'h0001, 16'h0, 4'd0, 4'd2, 1'b0, 1'b1, 4'd13, 5'b0);
    tick();
    checks++; if (bus.oNVZ !== 3'b100) begin errors++; $display("FAIL pre_rst_nvz: got %b want 100", bus.oNVZ); end
    drive(5'b01110, 16'h0003, 16'h0005, 16'h0, 4'd1, 4'd2, 1'b0, 1'b1, 4'd9, 5'b0);
    tick();
    nop();
    for (int i = 0; i < 7; i++) tick();
    checks++; if (bus.oStall !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b want 1", bus.oStall); end
    irst_n = 1'b0;
    #1;
    checks++; if (bus.oStall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b want 0", bus.oStall); end
    checks++; if (bus.oResult !== 16'h0 || bus.oWriteReg !== 1'b0 || bus.oNVZ !== 3'b000) begin errors++; $display("FAIL rst_mid_outputs: got %h wr=%b nvz=%b want 0000 0 000", bus.oResult, bus.oWriteReg, bus.oNVZ); end
    #10;
    irst_n = 1'b1;
    drive(5'b00000, 16'h0002, 16'h0003, 16'h0, 4'd1, 4'd2, 1'b0, 1'b1, 4'd6, 5'b0);
    tick();
    checks++; if (bus.oResult !== 16'h0005 || bus.oWriteReg !== 1'b1 || bus.oStall !== 1'b0) begin errors++; $display("FAIL post_rst_add: got %h wr=%b stall=%b want 0005 1 0", bus.oResult, bus.oWriteReg, bus.oStall); end
  endtask

  task automatic test_imm();
    drive(5'b00000, 16'h8000, 16'h8000, 16'h0, 4'd1, 4'd2, 1'b0, 1'b1, 4'd3, 5'b0);
    tick();
    checks++; if (bus.oResult !== 16'h0000 || bus.oNVZ !== 3'b011) begin errors++; $display("FAIL add_ovf: got %h nvz=%b want 0000 011", bus.oResult, bus.oNVZ); end
    drive(5'b01001, 16'h1234, 16'h0000, 16'hAB00, 4'd1, 4'd2, 1'b1, 1'b1, 4'd4, 5'b0);
    tick();
    checks++; if (bus.oResult !== 16'hAB34 || bus.oNVZ !== 3'b011) begin errors++; $display("FAIL immh: got %h nvz=%b want ab34 011", bus.oResult, bus.oNVZ); end
    drive(5'b01000, 16'h1234, 16'h0000, 16'h00CD, 4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 5'b0);
    tick();
    checks++; if (bus.oResult !== 16'h12CD) begin errors++; $display("FAIL imml: got %h want 12cd", bus.oResult); end
    drive(5'b11111, 16'h1234, 16'h4321, 16'h0, 4'd1, 4'd2, 1'b0, 1'b1, 4'd6, 5'b0);
    tick();
    checks++; if (bus.oResult !== 16'h0000 || bus.oNVZ !== 3'b011) begin errors++; $display("FAIL undef_op: got %h nvz=%b want 0000 011", bus.oResult, bus.oNVZ); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    irst_n = 1'b0;
    test_reset();
    test_add_sub();
    test_forwarding();
    test_load_store();
    test_mul(16'h0012, 16'h0034, 16'h03A8);
    test_mul(16'hFFFF, 16'hFFFF, 16'h0001);
    test_reset_mid_mul();
    test_imm();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
